// File: rtl/axi_bridge_pkg.sv
// axi_bridge_pkg: fixed AXI3 field encodings and FSM states
// shared by the core's AXI master bridge.
package axi_bridge_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_LOCK_NORM  = 2'b00;
   localparam logic [3:0] AXI_CACHE_NONE = 4'h0;
   localparam logic [2:0] AXI_PROT_NONE  = 3'h0;
   localparam logic [3:0] AXI_WR_ID      = 4'hF;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic {
      AR_IDLE,
      AR_SEND
   } ar_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_AW,
      W_DATA,
      W_RESP
   } w_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request
// at or after last+1 (mod N) wins.
module rr_arbiter
   import axi_bridge_pkg::*;
#(
   parameter int N  = 2,
   parameter int LW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [LW-1:0] last,
   output logic [N-1:0]  gnt
);

   // Walk distances from far to near so the nearest winner overwrites.
   always_comb begin
      gnt = '0;
      for (int k = N; k >= 1; k--) begin
         for (int i = 0; i < N; i++) begin
            if (i == (int'(last) + k) % N && req[i]) begin
               gnt    = '0;
               gnt[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/axi_multi_bridge.sv
// axi_multi_bridge: AXI3 master for NRD read clients (ARID =
// client index) and one burst write client.
module axi_multi_bridge
   import axi_bridge_pkg::*;
#(
   parameter int NRD    = 2,
   parameter int MAXLEN = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NRD-1:0]    rd_req,
   input  logic [NRD*32-1:0] rd_addr,
   input  logic [NRD*8-1:0]  rd_len,
   input  logic [NRD*3-1:0]  rd_size,
   output logic [NRD-1:0]    rd_gnt,
   output logic [NRD-1:0]    rd_valid,
   output logic              rd_last,
   output logic              rd_err,
   output logic [31:0]       rd_data,
   input  logic              wr_req,
   input  logic [31:0]       wr_addr,
   input  logic [7:0]        wr_len,
   input  logic [2:0]        wr_size,
   output logic              wr_gnt,
   input  logic [31:0]       wr_data,
   input  logic [3:0]        wr_strb,
   input  logic              wr_data_valid,
   output logic              wr_data_ready,
   output logic              wr_done,
   output logic              wr_err,
   output logic [3:0]        arid,
   output logic [31:0]       araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic [1:0]        arlock,
   output logic [3:0]        arcache,
   output logic [2:0]        arprot,
   output logic              arvalid,
   input  logic              arready,
   input  logic [3:0]        rid,
   input  logic [31:0]       rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,
   output logic [3:0]        awid,
   output logic [31:0]       awaddr,
   output logic [7:0]        awlen,
   output logic [2:0]        awsize,
   output logic [1:0]        awburst,
   output logic [1:0]        awlock,
   output logic [3:0]        awcache,
   output logic [2:0]        awprot,
   output logic              awvalid,
   input  logic              awready,
   output logic [3:0]        wid,
   output logic [31:0]       wdata,
   output logic [3:0]        wstrb,
   output logic              wlast,
   output logic              wvalid,
   input  logic              wready,
   input  logic [3:0]        bid,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready
);

   localparam int LW = (NRD > 1) ? $clog2(NRD) : 1;
   localparam int CW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

   ar_state_t ar_state, ar_next;
   w_state_t  w_state, w_next;

   logic [NRD-1:0] busy, busy_nxt, elig, arb_gnt;
   logic [LW-1:0]  last, sel, gnt_idx;
   logic [31:0]    ar_addr_q, pick_addr;
   logic [7:0]     ar_len_q, pick_len;
   logic [2:0]     ar_size_q, pick_size;

   logic [31:0]    w_addr_q;
   logic [7:0]     w_len_q;
   logic [2:0]     w_size_q;
   logic [CW-1:0]  w_cnt;
   logic           w_active, w_last_c, w_hs;
   logic           unused_bid;

   assign unused_bid = ^bid;
   assign w_active   = (w_state != W_IDLE);

   // A read hitting the in-flight write's 16-byte line waits for it.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NRD; i++) begin
         elig[i] = rd_req[i] & ~busy[i]
                 & ~(w_active && rd_addr[32*i+4 +: 28] == w_addr_q[31:4]);
      end
   end

   rr_arbiter #(.N(NRD), .LW(LW)) u_arb (
      .req  (elig),
      .last (last),
      .gnt  (arb_gnt)
   );

   always_comb begin
      gnt_idx   = '0;
      pick_addr = '0;
      pick_len  = '0;
      pick_size = '0;
      for (int i = 0; i < NRD; i++) begin
         if (arb_gnt[i]) begin
            gnt_idx   = LW'(i);
            pick_addr = rd_addr[32*i +: 32];
            pick_len  = rd_len[8*i +: 8];
            pick_size = rd_size[3*i +: 3];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) ar_state <= AR_IDLE;
      else       ar_state <= ar_next;
   end

   always_comb begin
      ar_next = ar_state;
      unique case (ar_state)
         AR_IDLE: if (|arb_gnt) ar_next = AR_SEND;
         AR_SEND: if (arready)  ar_next = AR_IDLE;
         default: ar_next = AR_IDLE;
      endcase
   end

   always_comb begin
      rd_gnt  = '0;
      arvalid = 1'b0;
      unique case (ar_state)
         AR_IDLE: rd_gnt  = reset ? '0 : arb_gnt;
         AR_SEND: arvalid = 1'b1;
         default: ;
      endcase
   end

   // Last beat clears before a new issue sets, so same-cycle reuse is safe.
   always_comb begin
      busy_nxt = busy;
      for (int i = 0; i < NRD; i++) begin
         if (rvalid && rlast && rid == 4'(i))
            busy_nxt[i] = 1'b0;
         if (ar_state == AR_SEND && arready && sel == LW'(i))
            busy_nxt[i] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy      <= '0;
         last      <= LW'(NRD-1);
         sel       <= '0;
         ar_addr_q <= '0;
         ar_len_q  <= '0;
         ar_size_q <= '0;
      end else begin
         busy <= busy_nxt;
         if (ar_state == AR_IDLE && |arb_gnt) begin
            sel       <= gnt_idx;
            ar_addr_q <= pick_addr;
            ar_len_q  <= pick_len;
            ar_size_q <= pick_size;
         end
         if (ar_state == AR_SEND && arready)
            last <= sel;
      end
   end

   assign arid    = 4'(sel);
   assign araddr  = ar_addr_q;
   assign arlen   = ar_len_q;
   assign arsize  = ar_size_q;
   assign arburst = AXI_BURST_INCR;
   assign arlock  = AXI_LOCK_NORM;
   assign arcache = AXI_CACHE_NONE;
   assign arprot  = AXI_PROT_NONE;

   assign rready  = 1'b1;
   assign rd_data = rdata;
   assign rd_last = rlast;
   assign rd_err  = (rresp != AXI_RESP_OKAY);

   always_comb begin
      rd_valid = '0;
      for (int i = 0; i < NRD; i++)
         rd_valid[i] = rvalid && rid == 4'(i);
   end

   assign w_last_c = (8'(w_cnt) == w_len_q);
   assign w_hs     = (w_state == W_DATA) && wr_data_valid && wready;

   always_ff @(posedge clock) begin
      if (reset) w_state <= W_IDLE;
      else       w_state <= w_next;
   end

   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE: if (wr_req)             w_next = W_AW;
         W_AW:   if (awready)            w_next = W_DATA;
         W_DATA: if (w_hs && w_last_c)   w_next = W_RESP;
         W_RESP: if (bvalid)             w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      wr_gnt        = 1'b0;
      awvalid       = 1'b0;
      wvalid        = 1'b0;
      wr_data_ready = 1'b0;
      wlast         = 1'b0;
      bready        = 1'b0;
      wr_done       = 1'b0;
      wr_err        = 1'b0;
      unique case (w_state)
         W_IDLE: wr_gnt = wr_req & ~reset;
         W_AW:   awvalid = 1'b1;
         W_DATA: begin
            wvalid        = wr_data_valid;
            wr_data_ready = wready;
            wlast         = w_last_c;
         end
         W_RESP: begin
            bready  = 1'b1;
            wr_done = bvalid;
            wr_err  = bvalid && (bresp != AXI_RESP_OKAY);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         w_addr_q <= '0;
         w_len_q  <= '0;
         w_size_q <= '0;
         w_cnt    <= '0;
      end else begin
         if (w_state == W_IDLE && wr_req) begin
            w_addr_q <= wr_addr;
            w_len_q  <= wr_len;
            w_size_q <= wr_size;
            w_cnt    <= '0;
         end else if (w_hs) begin
            w_cnt <= w_cnt + 1'b1;
         end
      end
   end

   assign awid    = AXI_WR_ID;
   assign awaddr  = w_addr_q;
   assign awlen   = w_len_q;
   assign awsize  = w_size_q;
   assign awburst = AXI_BURST_INCR;
   assign awlock  = AXI_LOCK_NORM;
   assign awcache = AXI_CACHE_NONE;
   assign awprot  = AXI_PROT_NONE;
   assign wid     = AXI_WR_ID;
   assign wdata   = wr_data;
   assign wstrb   = wr_strb;

endmodule

// File: tb/tb_axi_multi_bridge.sv
// tb_axi_multi_bridge: directed bus scenarios with read/write
// beat scoreboards for the AXI multi-client bridge.
module tb_axi_multi_bridge;

   localparam int NRD = 2;

   typedef struct {
      int unsigned cli;
      logic [31:0] data;
      logic        last;
      logic        err;
   } rexp_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } wexp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   logic [NRD-1:0]    rd_req;
   logic [NRD*32-1:0] rd_addr;
   logic [NRD*8-1:0]  rd_len;
   logic [NRD*3-1:0]  rd_size;
   logic [NRD-1:0]    rd_gnt, rd_valid;
   logic              rd_last, rd_err;
   logic [31:0]       rd_data;
   logic              wr_req;
   logic [31:0]       wr_addr;
   logic [7:0]        wr_len;
   logic [2:0]        wr_size;
   logic              wr_gnt;
   logic [31:0]       wr_data;
   logic [3:0]        wr_strb;
   logic              wr_data_valid, wr_data_ready, wr_done, wr_err;
   logic [3:0]        arid;
   logic [31:0]       araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst, arlock;
   logic [3:0]        arcache;
   logic [2:0]        arprot;
   logic              arvalid, arready;
   logic [3:0]        rid;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rlast, rvalid, rready;
   logic [3:0]        awid;
   logic [31:0]       awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst, awlock;
   logic [3:0]        awcache;
   logic [2:0]        awprot;
   logic              awvalid, awready;
   logic [3:0]        wid;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wlast, wvalid, wready;
   logic [3:0]        bid;
   logic [1:0]        bresp;
   logic              bvalid, bready;

   int checks = 0;
   int errors = 0;
   rexp_t rq[$];
   wexp_t wq[$];

   always #5 clock = ~clock;

   axi_multi_bridge #(.NRD(NRD), .MAXLEN(16)) dut (
      .clock(clock), .reset(reset),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
      .rd_size(rd_size), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
      .rd_last(rd_last), .rd_err(rd_err), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
      .wr_size(wr_size), .wr_gnt(wr_gnt), .wr_data(wr_data),
      .wr_strb(wr_strb), .wr_data_valid(wr_data_valid),
      .wr_data_ready(wr_data_ready), .wr_done(wr_done),
      .wr_err(wr_err),
      .arid(arid), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arburst(arburst), .arlock(arlock),
      .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
      .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen),
      .awsize(awsize), .awburst(awburst), .awlock(awlock),
      .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
      .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Read return scoreboard
   always @(negedge clock) begin
      rexp_t e;
      int cli;
      if (!reset && rd_valid != '0) begin
         chk("rd_pending", 64'(rq.size() != 0), 64'(1));
         if (rq.size() != 0) begin
            e = rq.pop_front();
            cli = 0;
            for (int i = 0; i < NRD; i++)
               if (rd_valid[i]) cli = i;
            chk("rd_onehot", 64'($countones(rd_valid)), 64'(1));
            chk("rd_client", 64'(cli), 64'(e.cli));
            chk("rd_data", 64'(rd_data), 64'(e.data));
            chk("rd_last", 64'(rd_last), 64'(e.last));
            chk("rd_err", 64'(rd_err), 64'(e.err));
         end
      end
   end

   // Write beat scoreboard
   always @(negedge clock) begin
      wexp_t e;
      if (!reset && wvalid && wready) begin
         chk("w_pending", 64'(wq.size() != 0), 64'(1));
         if (wq.size() != 0) begin
            e = wq.pop_front();
            chk("w_data", 64'(wdata), 64'(e.data));
            chk("w_strb", 64'(wstrb), 64'(e.strb));
            chk("w_last", 64'(wlast), 64'(e.last));
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      rd_req = '0; rd_addr = '0; rd_len = '0; rd_size = '0;
      wr_req = 0; wr_addr = 0; wr_len = 0; wr_size = 0;
      wr_data = 0; wr_strb = 0; wr_data_valid = 0;
      arready = 0; rvalid = 0; rlast = 0; rid = 0;
      rdata = 0; rresp = 0; awready = 0; wready = 0;
      bvalid = 0; bresp = 0; bid = 4'hF;
      rq.delete();
      wq.delete();
      cyc();
      cyc();
      @(negedge clock);
      chk("rst_arvalid", 64'(arvalid), 64'(0));
      chk("rst_awvalid", 64'(awvalid), 64'(0));
      chk("rst_wvalid", 64'(wvalid), 64'(0));
      chk("rst_bready", 64'(bready), 64'(0));
      chk("rst_rd_gnt", 64'(rd_gnt), 64'(0));
      chk("rst_wr_gnt", 64'(wr_gnt), 64'(0));
      chk("rst_wr_done", 64'(wr_done), 64'(0));
      chk("rst_rready", 64'(rready), 64'(1));
      cyc();
      reset = 1'b0;
   endtask

   task automatic set_rd(input int c, input logic [31:0] a,
                         input logic [7:0] l);
      rd_addr[c*32 +: 32] = a;
      rd_len[c*8 +: 8]    = l;
      rd_size[c*3 +: 3]   = 3'd2;
   endtask

   task automatic ar_accept(input string tg, input int id,
                            input logic [31:0] a, input logic [7:0] l);
      @(negedge clock);
      chk({tg, "_arvalid"}, 64'(arvalid), 64'(1));
      chk({tg, "_arid"}, 64'(arid), 64'(id));
      chk({tg, "_araddr"}, 64'(araddr), 64'(a));
      chk({tg, "_arlen"}, 64'(arlen), 64'(l));
      chk({tg, "_arburst"}, 64'(arburst), 64'(2'b01));
      chk({tg, "_gnt_send"}, 64'(rd_gnt), 64'(0));
      arready = 1'b1;
      cyc();
      arready = 1'b0;
   endtask

   task automatic rbeat_drive(input int id, input logic [31:0] d,
                              input logic l, input logic [1:0] r);
      rexp_t e;
      rid = 4'(id); rdata = d; rlast = l; rresp = r; rvalid = 1'b1;
      if (id < NRD) begin
         e.cli = id; e.data = d; e.last = l; e.err = (r != 2'b00);
         rq.push_back(e);
      end
   endtask

   task automatic rbeat(input int id, input logic [31:0] d,
                        input logic l, input logic [1:0] r);
      rbeat_drive(id, d, l, r);
      cyc();
      rvalid = 1'b0;
   endtask

   task automatic wpush(input logic [31:0] d, input logic l);
      wexp_t e;
      wr_data = d; wr_strb = 4'hF;
      e.data = d; e.strb = 4'hF; e.last = l;
      wq.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      // Single burst from client 0
      do_reset();
      set_rd(0, 32'h1C00_0000, 8'd3);
      rd_req = 2'b01;
      @(negedge clock);
      chk("t1_gnt", 64'(rd_gnt), 64'(2'b01));
      cyc();
      rd_req = '0;
      ar_accept("t1", 0, 32'h1C00_0000, 8'd3);
      @(negedge clock);
      chk("t1_arv_low", 64'(arvalid), 64'(0));
      cyc();
      for (int b = 0; b < 4; b++)
         rbeat(0, 32'hA000_0000 + 32'(b), b == 3, 2'b00);

      // Both clients held: 0 then 1, interleaved returns
      do_reset();
      set_rd(0, 32'h0000_0100, 8'd1);
      set_rd(1, 32'h0000_0200, 8'd1);
      rd_req = 2'b11;
      @(negedge clock);
      chk("t2_gnt0", 64'(rd_gnt), 64'(2'b01));
      cyc();
      rd_req = 2'b10;
      ar_accept("t2a", 0, 32'h0000_0100, 8'd1);
      @(negedge clock);
      chk("t2_gnt1", 64'(rd_gnt), 64'(2'b10));
      cyc();
      rd_req = '0;
      ar_accept("t2b", 1, 32'h0000_0200, 8'd1);
      rbeat(1, 32'h11, 1'b0, 2'b00);
      rbeat_drive(5, 32'hDEAD, 1'b1, 2'b00);
      @(negedge clock);
      chk("t2_drop", 64'(rd_valid), 64'(0));
      cyc();
      rvalid = 1'b0;
      rbeat(0, 32'h20, 1'b0, 2'b10);
      rbeat(1, 32'h12, 1'b1, 2'b00);
      rbeat(0, 32'h21, 1'b1, 2'b00);

      // Busy client skipped; re-granted only after its rlast
      do_reset();
      set_rd(0, 32'h0000_0300, 8'd0);
      set_rd(1, 32'h0000_0400, 8'd0);
      rd_req = 2'b01;
      @(negedge clock);
      chk("t3_gnt0", 64'(rd_gnt), 64'(2'b01));
      cyc();
      rd_req = '0;
      ar_accept("t3a", 0, 32'h0000_0300, 8'd0);
      rd_req = 2'b11;
      @(negedge clock);
      chk("t3_gnt1", 64'(rd_gnt), 64'(2'b10));
      cyc();
      rd_req = 2'b01;
      ar_accept("t3b", 1, 32'h0000_0400, 8'd0);
      @(negedge clock);
      chk("t3_busy", 64'(rd_gnt), 64'(0));
      cyc();
      rbeat_drive(0, 32'h30, 1'b1, 2'b00);
      @(negedge clock);
      chk("t3_same_cyc", 64'(rd_gnt), 64'(0));
      cyc();
      rvalid = 1'b0;
      @(negedge clock);
      chk("t3_regnt", 64'(rd_gnt), 64'(2'b01));
      cyc();
      rd_req = '0;
      ar_accept("t3c", 0, 32'h0000_0300, 8'd0);
      rbeat(1, 32'h40, 1'b1, 2'b00);
      rbeat(0, 32'h31, 1'b1, 2'b00);

      // Two-beat write with wready stall and SLVERR response
      do_reset();
      wr_addr = 32'h1FAF_0010; wr_len = 8'd1; wr_size = 3'd2;
      wr_req = 1'b1;
      @(negedge clock);
      chk("t4_wr_gnt", 64'(wr_gnt), 64'(1));
      chk("t4_aw_early", 64'(awvalid), 64'(0));
      cyc();
      wr_req = 1'b0;
      wpush(32'hCAFE_0000, 1'b0);
      wr_data_valid = 1'b1;
      @(negedge clock);
      chk("t4_awvalid", 64'(awvalid), 64'(1));
      chk("t4_awaddr", 64'(awaddr), 64'(32'h1FAF_0010));
      chk("t4_awlen", 64'(awlen), 64'(1));
      chk("t4_awid", 64'(awid), 64'(4'hF));
      chk("t4_w_early", 64'(wvalid), 64'(0));
      awready = 1'b1;
      cyc();
      awready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clock);
         chk("t4_stall_wvalid", 64'(wvalid), 64'(1));
         chk("t4_stall_wlast", 64'(wlast), 64'(0));
         chk("t4_stall_rdy", 64'(wr_data_ready), 64'(0));
         cyc();
      end
      wready = 1'b1;
      @(negedge clock);
      chk("t4_b0_wlast", 64'(wlast), 64'(0));
      chk("t4_b0_rdy", 64'(wr_data_ready), 64'(1));
      cyc();
      wpush(32'hCAFE_0001, 1'b1);
      @(negedge clock);
      chk("t4_b1_wlast", 64'(wlast), 64'(1));
      cyc();
      wready = 1'b0;
      wr_data_valid = 1'b0;
      @(negedge clock);
      chk("t4_bready", 64'(bready), 64'(1));
      chk("t4_w_done", 64'(wvalid), 64'(0));
      bvalid = 1'b1;
      bresp = 2'b10;
      #1;
      chk("t4_wr_done", 64'(wr_done), 64'(1));
      chk("t4_wr_err", 64'(wr_err), 64'(1));
      cyc();
      bvalid = 1'b0;
      @(negedge clock);
      chk("t4_done_pulse", 64'(wr_done), 64'(0));
      chk("t4_bready_off", 64'(bready), 64'(0));
      cyc();

      // Same-line read waits for the write, other line proceeds
      do_reset();
      wr_addr = 32'h0000_1000; wr_len = 8'd0; wr_req = 1'b1;
      cyc();
      wr_req = 1'b0;
      set_rd(0, 32'h0000_1008, 8'd0);
      set_rd(1, 32'h0000_2000, 8'd0);
      rd_req = 2'b11;
      @(negedge clock);
      chk("t5_gnt_other", 64'(rd_gnt), 64'(2'b10));
      cyc();
      rd_req = 2'b01;
      ar_accept("t5a", 1, 32'h0000_2000, 8'd0);
      @(negedge clock);
      chk("t5_blk_aw", 64'(rd_gnt), 64'(0));
      awready = 1'b1;
      cyc();
      awready = 1'b0;
      wpush(32'h5555_AAAA, 1'b1);
      wr_data_valid = 1'b1;
      wready = 1'b1;
      @(negedge clock);
      chk("t5_blk_data", 64'(rd_gnt), 64'(0));
      chk("t5_wvalid", 64'(wvalid), 64'(1));
      cyc();
      wr_data_valid = 1'b0;
      wready = 1'b0;
      bvalid = 1'b1;
      bresp = 2'b00;
      @(negedge clock);
      chk("t5_wr_done", 64'(wr_done), 64'(1));
      chk("t5_wr_ok", 64'(wr_err), 64'(0));
      chk("t5_blk_resp", 64'(rd_gnt), 64'(0));
      cyc();
      bvalid = 1'b0;
      @(negedge clock);
      chk("t5_unblocked", 64'(rd_gnt), 64'(2'b01));
      cyc();
      rd_req = '0;

      // Reset in AR_SEND and W_DATA with client 1 busy
      do_reset();
      set_rd(1, 32'h0000_4000, 8'd0);
      rd_req = 2'b10;
      cyc();
      rd_req = '0;
      ar_accept("t6a", 1, 32'h0000_4000, 8'd0);
      set_rd(0, 32'h0000_5000, 8'd0);
      rd_req = 2'b01;
      wr_addr = 32'h0000_6000; wr_len = 8'd3; wr_req = 1'b1;
      @(negedge clock);
      chk("t6_rd_gnt", 64'(rd_gnt), 64'(2'b01));
      chk("t6_wr_gnt", 64'(wr_gnt), 64'(1));
      cyc();
      rd_req = '0;
      wr_req = 1'b0;
      @(negedge clock);
      chk("t6_ar_both", 64'(arvalid), 64'(1));
      chk("t6_aw_both", 64'(awvalid), 64'(1));
      awready = 1'b1;
      cyc();
      awready = 1'b0;
      wr_data_valid = 1'b1;
      @(negedge clock);
      chk("t6_pre_wvalid", 64'(wvalid), 64'(1));
      chk("t6_pre_arvalid", 64'(arvalid), 64'(1));
      reset = 1'b1;
      cyc();
      @(negedge clock);
      chk("t6_rst_arvalid", 64'(arvalid), 64'(0));
      chk("t6_rst_awvalid", 64'(awvalid), 64'(0));
      chk("t6_rst_wvalid", 64'(wvalid), 64'(0));
      chk("t6_rst_bready", 64'(bready), 64'(0));
      cyc();
      reset = 1'b0;
      wr_data_valid = 1'b0;
      rd_req = 2'b10;
      @(negedge clock);
      chk("t6_busy_clr", 64'(rd_gnt), 64'(2'b10));
      cyc();
      rd_req = '0;
      cyc();

      chk("rq_drained", 64'(rq.size()), 64'(0));
      chk("wq_drained", 64'(wq.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_multi_bridge.md
# axi_multi_bridge

Parametrised AXI3 master bridge between the core's memory clients and the SoC bus. It serves `NRD` independent read clients (e.g. icache, dcache, uncached load) with round-robin arbitration, one outstanding burst per client, and ID-based return routing. It also serves one burst write client. It sits directly below the core top level and drives the core's AXI ports.

## Interface
Parameters:
- `NRD`, 2, number of read clients (1..16); client index is used as ARID.
- `MAXLEN`, 16, maximum beats per burst; `rd_len`/`wr_len` carry beats-1.

Ports:
- `clock`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `rd_req`  in  NRD  read request per client, held until granted.
- `rd_addr`  in  NRD*32  per-client byte address (client i at bits [32i+31:32i]).
- `rd_len`  in  NRD*8  per-client beats-1.
- `rd_size`  in  NRD*3  per-client AXI size.
- `rd_gnt`  out  NRD  one-cycle pulse: request latched.
- `rd_valid`  out  NRD  return beat valid for client i.
- `rd_last`  out  1  current beat is last of burst.
- `rd_err`  out  1  current beat rresp != OKAY.
- `rd_data`  out  32  shared return data.
- `wr_req`, `wr_addr`[32], `wr_len`[8], `wr_size`[3]  in  write burst request, held until `wr_gnt`.
- `wr_gnt`  out  1  one-cycle pulse: write request latched.
- `wr_data`  in  32  write beat data.
- `wr_strb`  in  4  write beat strobes.
- `wr_data_valid`  in  1  write beat valid.
- `wr_data_ready`  out  1  write beat accepted.
- `wr_done`  out  1  one-cycle pulse on B response.
- `wr_err`  out  1  valid with `wr_done`: bresp != OKAY.
- `arid`[4] `araddr`[32] `arlen`[8] `arsize`[3] `arburst`[2] `arlock`[2] `arcache`[4] `arprot`[3] `arvalid`  out; `arready`  in.
- `rid`[4] `rdata`[32] `rresp`[2] `rlast` `rvalid`  in; `rready`  out.
- `awid`[4] `awaddr`[32] `awlen`[8] `awsize`[3] `awburst`[2] `awlock`[2] `awcache`[4] `awprot`[3] `awvalid`  out; `awready`  in.
- `wid`[4] `wdata`[32] `wstrb`[4] `wlast` `wvalid`  out; `wready`  in.
- `bid`[4] `bresp`[2] `bvalid`  in; `bready`  out.

## Operation
- Constant fields:
  - `arburst`=`awburst`=INCR (01).
  - `arlock`=`awlock`=0, `arcache`=`awcache`=0, `arprot`=`awprot`=0.
  - `awid`=`wid`=4'hF.
- Read issue FSM, states AR_IDLE and AR_SEND:
  - AR_IDLE: eligible clients have `rd_req`=1 and `busy[i]`=0.
  - Pick the first eligible client at or after `last+1` (mod NRD).
  - Latch its addr/len/size, pulse `rd_gnt[i]`, set `arid`=i, go to AR_SEND.
  - AR_SEND: `arvalid`=1. On `arready`, set `busy[i]`, set `last`=i, go to AR_IDLE.
- Read return:
  - `rready`=1 constantly.
  - For rid < NRD: `rd_valid[rid]`=`rvalid`; `rd_data`=`rdata`, `rd_last`=`rlast`, `rd_err`=(`rresp`!=0).
  - On `rvalid`&`rlast`, clear `busy[rid]`.
  - A beat with rid >= NRD is consumed and dropped.
- Write FSM, states W_IDLE → W_AW → W_DATA → W_RESP:
  - W_IDLE: on `wr_req`, latch the request, pulse `wr_gnt`, clear the beat counter.
  - W_AW: `awvalid`=1 until `awready`.
  - W_DATA: `wvalid`=`wr_data_valid`, `wr_data_ready`=`wready`, `wlast`=(count==len). Count increments per handshake; leave after the last handshake.
  - W_RESP: `bready`=1. On `bvalid`, pulse `wr_done`/`wr_err`, go to W_IDLE.
- RAW hazard: a read whose `addr[31:4]` equals the latched write `addr[31:4]` is ineligible while the write FSM is not W_IDLE.

## Timing
- Reset values:
  - `arvalid`, `awvalid`, `wvalid`, `bready`, `rd_gnt`, `wr_gnt`, `wr_done`: 0.
  - `busy`: 0; `last` = NRD-1, so client 0 wins first; both FSMs idle.
  - `rready` is 1 in every cycle, including reset.
- Latencies:
  - `rd_gnt` is asserted in the cycle `rd_req` is seen; `arvalid` rises the following cycle.
  - Return path is combinational: `rd_valid` is in the same cycle as `rvalid`.
  - `wr_gnt` is in the `wr_req` cycle; `awvalid` follows one cycle later.
  - First `wvalid` is no earlier than the cycle after the `awready` handshake.
- Handshakes:
  - `arvalid`, `awvalid` and all AR/AW payloads are held stable until ready.
  - `wvalid` may deassert only when the client withdraws `wr_data_valid`.
- Simultaneous events:
  - The last return beat and a new request for the same client in the same cycle: the client is eligible next cycle, not this one.
  - The read and write FSMs are independent; AR and AW may be issued in the same cycle.
- Reset mid-burst returns every FSM to idle and clears `busy`. The bus side is expected to be reset together.

## Structure
- Package `axi_bridge_pkg`: burst/lock/cache/prot constants, write ID 4'hF, the OKAY encoding, and the AR/W state enums.
- One sub-module, `rr_arbiter`:
  - Parameter `N`.
  - Inputs `req[N]`, `last`; output one-hot `gnt[N]`.
  - Purely combinational.

## Test plan
- Reset, then `rd_req`=01, addr 0x1C000000, len 3 → `rd_gnt`=01, then `arid`=0, `arlen`=3. Four beats with rid=0 → `rd_valid[0]` ×4 with `rd_last` on the 4th.
- `rd_req`=11 held after reset → grants alternate client 0 then 1. Returns interleaved by rid are routed correctly.
- Client 0 busy and re-requesting while client 1 idle: client 1 is granted; client 0 is re-granted only after its `rlast`.
- Write addr 0x1FAF0010, len 1; `wready` stalls on beat 0 for 3 cycles → `wlast` only on the 2nd beat, then `bvalid` with bresp=2 → `wr_done`=1, `wr_err`=1.
- Write in flight to 0x1000; read to 0x1008 blocked until `wr_done`; read to 0x2000 is granted immediately.
- Assert `reset` during AR_SEND and W_DATA → next cycle all valids 0 and `busy`=0.
